ga_issue_ctrl: RTL

GA_ISSUE_CTRL -- requirements
Module: ga_issue_ctrl

---
 rtl/ga_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ga_issue_ctrl.sv
// -----------------------------------------------------------------------------
// ga_issue_ctrl
//
// Purpose:
//   Issue controller sitting between a scalar core and a geometric-algebra (GA)
//   coprocessor. It accepts one custom instruction at a time, decodes it, issues
//   a request to the coprocessor, waits for the response and returns a single
//   completion pulse (result, destination register, error flag) to the core.
//   Illegal instructions complete immediately with an error and never reach the
//   coprocessor.
//
// Optional feature:
//   GA_ISSUE_TIMEOUT_EN - when defined, an 8-bit watchdog counts cycles spent in
//   ISSUE+WAIT and forces an error completion after TIMEOUT_CYCLES cycles.
//   When undefined there is no counter and the block waits indefinitely.
//
// Handshakes:
//   Core side  : an instruction transfers on a rising edge where
//                instr_valid_i && instr_ready_o. instr_ready_o is high only in
//                IDLE, so at most one instruction is in flight.
//   Coproc req : ga_req_o.valid is raised in ISSUE and the request fields are
//                held stable until a rising edge samples ga_resp_i.ready high;
//                the request is then considered taken and valid drops.
//   Coproc resp: ga_resp_i.valid is only looked at in WAIT; a response arriving
//                in any other state is ignored.
//   Completion : result_valid_o is a one-cycle pulse; result_o, result_rd_o and
//                result_err_o hold their values until the next completion.
//
// Ports:
//   clk_i           - clock, rising edge
//   rst_i           - asynchronous active-high reset
//   instr_valid_i   - core presents an instruction
//   instr_i[31:0]   - instruction word
//   rs1_rdata_i     - operand A from the core register file
//   rs2_rdata_i     - operand B from the core register file
//   instr_ready_o   - block can accept an instruction this cycle
//   ga_req_o        - request bundle to the coprocessor (ga_req_t)
//   ga_resp_i       - response bundle from the coprocessor (ga_resp_t)
//   result_valid_o  - one-cycle completion pulse
//   result_o[31:0]  - completion data
//   result_rd_o     - completion destination register
//   result_err_o    - completion carries an error
//   busy_o          - high in any state other than IDLE
//   dbg_state_o     - current FSM state, for observation only
// -----------------------------------------------------------------------------

package ga_issue_pkg;

   localparam logic [6:0] GA_OPCODE = 7'h0B;

   localparam logic [3:0] GA_FUNCT_ADD     = 4'h0;
   localparam logic [3:0] GA_FUNCT_SUB     = 4'h1;
   localparam logic [3:0] GA_FUNCT_MUL     = 4'h2;
   localparam logic [3:0] GA_FUNCT_WEDGE   = 4'h3;
   localparam logic [3:0] GA_FUNCT_DOT     = 4'h4;
   localparam logic [3:0] GA_FUNCT_DUAL    = 4'h5;
   localparam logic [3:0] GA_FUNCT_REV     = 4'h6;
   localparam logic [3:0] GA_FUNCT_NORM    = 4'h7;
   localparam logic [3:0] GA_FUNCT_LOAD    = 4'h8;
   localparam logic [3:0] GA_FUNCT_STORE   = 4'h9;
   localparam logic [3:0] GA_FUNCT_ROTATE  = 4'hA;
   localparam logic [3:0] GA_FUNCT_REFLECT = 4'hB;
   // Highest defined function code; anything above is illegal.
   localparam logic [3:0] GA_FUNCT_LAST    = GA_FUNCT_REFLECT;

   typedef struct packed {
      logic        valid;
      logic        we;          // 0 only for STORE (coprocessor register not written)
      logic [3:0]  funct;
      logic [4:0]  reg_a;
      logic [4:0]  reg_b;
      logic        use_ga_regs; // operands come from GA registers, not operand_a/b
      logic [4:0]  rd;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
   } ga_req_t;

   typedef struct packed {
      logic        ready;
      logic        valid;
      logic [31:0] result;
      logic        error;
      logic        overflow;
      logic        underflow;
   } ga_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } ga_state_e;

endpackage

module ga_issue_ctrl
   import ga_issue_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] rs1_rdata_i,
   input  logic [31:0] rs2_rdata_i,
   output logic        instr_ready_o,
   output ga_req_t     ga_req_o,
   input  ga_resp_t    ga_resp_i,
   output logic        result_valid_o,
   output logic [31:0] result_o,
   output logic [4:0]  result_rd_o,
   output logic        result_err_o,
   output logic        busy_o,
   output logic [1:0]  dbg_state_o
);

   // The watchdog counter is 8 bits wide, so the limit must fit in 1..255.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
      $error("ga_issue_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

   // ---------------------------------------------------------------------------
   // Instruction decode (combinational, only consumed in IDLE)
   // ---------------------------------------------------------------------------
   logic [6:0] dec_opcode;
   logic [4:0] dec_rd;
   logic [4:0] dec_reg_a;
   logic [4:0] dec_reg_b;
   logic [3:0] dec_funct;
   logic       dec_use_ga_regs;
   logic       dec_illegal;
   logic       unused_instr_bits;

   assign dec_opcode      = instr_i[6:0];
   assign dec_rd          = instr_i[11:7];
   assign dec_reg_a       = instr_i[19:15];
   assign dec_reg_b       = instr_i[24:20];
   assign dec_funct       = instr_i[28:25];
   assign dec_use_ga_regs = instr_i[31];
   assign dec_illegal     = (dec_opcode != GA_OPCODE) || (dec_funct > GA_FUNCT_LAST);
   // Bits 14:12 and 30:29 are reserved in this encoding.
   assign unused_instr_bits = ^{instr_i[30:29], instr_i[14:12]};

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   ga_state_e   state_q, state_d;
   ga_req_t     req_q, req_d;
   logic        res_valid_q, res_valid_d;
   logic [31:0] res_data_q, res_data_d;
   logic [4:0]  res_rd_q, res_rd_d;
   logic        res_err_q, res_err_d;
   logic        timeout_hit;

`ifdef GA_ISSUE_TIMEOUT_EN
   logic [7:0] tmo_cnt_q, tmo_cnt_d;

   // tmo_cnt_q counts completed ISSUE/WAIT cycles; the cycle in which it shows
   // TIMEOUT_CYCLES-1 is the last one, so the count reaches TIMEOUT_CYCLES on
   // the same edge that forces the completion.
   assign timeout_hit = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                        (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_err_d   = res_err_q;
`ifdef GA_ISSUE_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (instr_valid_i) begin
               if (dec_illegal) begin
                  // Complete straight away; the coprocessor never sees it.
                  state_d     = ST_RESP;
                  res_valid_d = 1'b1;
                  res_data_d  = '0;
                  res_rd_d    = dec_rd;
                  res_err_d   = 1'b1;
               end else begin
                  state_d           = ST_ISSUE;
                  req_d.valid       = 1'b1;
                  req_d.we          = (dec_funct != GA_FUNCT_STORE);
                  req_d.funct       = dec_funct;
                  req_d.reg_a       = dec_reg_a;
                  req_d.reg_b       = dec_reg_b;
                  req_d.use_ga_regs = dec_use_ga_regs;
                  req_d.rd          = dec_rd;
                  req_d.operand_a   = rs1_rdata_i;
                  req_d.operand_b   = rs2_rdata_i;
`ifdef GA_ISSUE_TIMEOUT_EN
                  tmo_cnt_d         = '0;
`endif
               end
            end
         end

         ST_ISSUE: begin
`ifdef GA_ISSUE_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
            // The watchdog wins over a coincident ready: the limit is absolute.
            if (timeout_hit) begin
               state_d     = ST_RESP;
               req_d.valid = 1'b0;
               res_valid_d = 1'b1;
               res_data_d  = '0;
               res_rd_d    = req_q.rd;
               res_err_d   = 1'b1;
            end else if (ga_resp_i.ready) begin
               // A response valid in this same cycle is deliberately not looked at.
               state_d     = ST_WAIT;
               req_d.valid = 1'b0;
            end
         end

         ST_WAIT: begin
`ifdef GA_ISSUE_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
            if (timeout_hit) begin
               state_d     = ST_RESP;
               res_valid_d = 1'b1;
               res_data_d  = '0;
               res_rd_d    = req_q.rd;
               res_err_d   = 1'b1;
            end else if (ga_resp_i.valid) begin
               state_d     = ST_RESP;
               res_valid_d = 1'b1;
               res_data_d  = ga_resp_i.result;
               res_rd_d    = req_q.rd;
               res_err_d   = ga_resp_i.error | ga_resp_i.overflow | ga_resp_i.underflow;
            end
         end

         ST_RESP: begin
            // The completion pulse was registered on entry; one cycle here only.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         res_err_q   <= 1'b0;
`ifdef GA_ISSUE_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_err_q   <= res_err_d;
`ifdef GA_ISSUE_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign instr_ready_o  = (state_q == ST_IDLE);
   assign busy_o         = (state_q != ST_IDLE);
   assign ga_req_o       = req_q;
   assign result_valid_o = res_valid_q;
   assign result_o       = res_data_q;
   assign result_rd_o    = res_rd_q;
   assign result_err_o   = res_err_q;
   assign dbg_state_o    = state_q;

endmodule
